countdown_sequencer: RTL and testbench

Control FSM for the egg-timer countdown datapath. Takes raw active-low SET and START/STOP keys plus a 1 Hz tick, and sequences a full timer cycle: seconds entry, minutes entry, run, pause, and alarm. It drives the load, decrement, flash and switch-display enables of the seconds/minutes decrementers and the flasher, and sits between the board keys and those datapath blocks in the top level.

---
 rtl/countdown_sequencer.sv | 168 ++++++++++++++++
 tb/tb_countdown_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_sequencer.sv
// Egg-timer control FSM: key synchronisation, entry validation, run/pause/alarm sequencing.
// Optional BCD entry validation and err flag are enabled by defining COUNTDOWN_BCD_CHECK_EN.
module countdown_sequencer #(
   parameter int unsigned ALARM_TICKS = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       set_n,
   input  logic       start_stop_n,
   input  logic       tick,
   input  logic [7:0] sw,
   input  logic       time_zero,
   output logic       secs_load,
   output logic       mins_load,
   output logic       dec_en,
   output logic       flash_en,
   output logic       sw_sec_en,
   output logic       sw_min_en,
   output logic       err,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SET_SECS = 3'd1,
      SET_MINS = 3'd2,
      READY    = 3'd3,
      RUN      = 3'd4,
      PAUSE    = 3'd5,
      ALARM    = 3'd6
   } state_t;

   localparam logic [7:0] ALARM_LIMIT = 8'(ALARM_TICKS);

   state_t     stateReg;
   state_t     nextState;
   logic [7:0] alarmCnt;
   logic [7:0] nextAlarmCnt;
   logic       nextSecsLoad;
   logic       nextMinsLoad;

   logic [1:0] setSync;
   logic [1:0] ssSync;
   logic       setPrev;
   logic       ssPrev;
   logic       setP;
   logic       ssP;

   logic       secsOk;
   logic       minsOk;

   // Two-flop synchronisers plus a registered falling-edge detector per key.
   always_ff @(posedge clk) begin
      if (reset) begin
         setSync <= 2'b11;
         ssSync  <= 2'b11;
         setPrev <= 1'b1;
         ssPrev  <= 1'b1;
         setP    <= 1'b0;
         ssP     <= 1'b0;
      end else begin
         setSync <= {setSync[0], set_n};
         ssSync  <= {ssSync[0], start_stop_n};
         setPrev <= setSync[1];
         ssPrev  <= ssSync[1];
         setP    <= setPrev & ~setSync[1];
         ssP     <= ssPrev & ~ssSync[1];
      end
   end

`ifdef COUNTDOWN_BCD_CHECK_EN
   logic errReg;

   assign minsOk = (sw[7:4] <= 4'd9) && (sw[3:0] <= 4'd9);
   assign secsOk = minsOk && (sw <= 8'h59);

   // err tracks the outcome of the most recent entry attempt.
   always_ff @(posedge clk) begin
      if (reset) begin
         errReg <= 1'b0;
      end else if (setP && (stateReg == SET_SECS)) begin
         errReg <= ~secsOk;
      end else if (setP && (stateReg == SET_MINS)) begin
         errReg <= ~minsOk;
      end
   end

   assign err = errReg;
`else
   logic unusedSw;

   assign unusedSw = ^sw;
   assign minsOk   = 1'b1;
   assign secsOk   = 1'b1;
   assign err      = 1'b0;
`endif

   always_comb begin
      nextState    = stateReg;
      nextAlarmCnt = alarmCnt;
      nextSecsLoad = 1'b0;
      nextMinsLoad = 1'b0;
      case (stateReg)
         IDLE: begin
            if (setP) nextState = SET_SECS;
         end
         SET_SECS: begin
            if (setP && secsOk) begin
               nextSecsLoad = 1'b1;
               nextState    = SET_MINS;
            end
         end
         SET_MINS: begin
            if (setP && minsOk) begin
               nextMinsLoad = 1'b1;
               nextState    = READY;
            end
         end
         READY: begin
            // A START/STOP press is consumed even when refused at 00:00.
            if (ssP) begin
               if (!time_zero) nextState = RUN;
            end else if (setP) begin
               nextState = SET_SECS;
            end
         end
         RUN: begin
            if (time_zero)  nextState = ALARM;
            else if (ssP)   nextState = PAUSE;
         end
         PAUSE: begin
            if (ssP)        nextState = RUN;
            else if (setP)  nextState = SET_SECS;
         end
         ALARM: begin
            if (ssP || setP || (alarmCnt == ALARM_LIMIT)) nextState = IDLE;
            else if (tick) nextAlarmCnt = alarmCnt + 8'd1;
         end
         default: nextState = IDLE;
      endcase
      if ((nextState == ALARM) && (stateReg != ALARM)) nextAlarmCnt = 8'd0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg  <= IDLE;
         alarmCnt  <= 8'd0;
         secs_load <= 1'b0;
         mins_load <= 1'b0;
         sw_sec_en <= 1'b0;
         sw_min_en <= 1'b0;
         flash_en  <= 1'b0;
      end else begin
         stateReg  <= nextState;
         alarmCnt  <= nextAlarmCnt;
         secs_load <= nextSecsLoad;
         mins_load <= nextMinsLoad;
         sw_sec_en <= (nextState == SET_SECS);
         sw_min_en <= (nextState == SET_MINS);
         flash_en  <= (nextState == ALARM);
      end
   end

   // Same-cycle decrement strobe; suppressed while reset is applied.
   assign dec_en = (stateReg == RUN) && tick && !time_zero && !reset;
   assign state  = stateReg;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Scoreboard bench for countdown_sequencer: event-level reference model feeds an expected
// queue of load/decrement strobes; a negedge monitor pops and compares them.
module tb_countdown_sequencer;

   localparam int ALARM_TICKS = 10;
   localparam int W = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       set_n = 1'b1;
   logic       start_stop_n = 1'b1;
   logic       tick = 1'b0;
   logic [7:0] sw = 8'h00;
   logic       time_zero = 1'b0;
   logic       secs_load;
   logic       mins_load;
   logic       dec_en;
   logic       flash_en;
   logic       sw_sec_en;
   logic       sw_min_en;
   logic       err;
   logic [2:0] state;

   countdown_sequencer #(.ALARM_TICKS(ALARM_TICKS)) dut (
      .clk(clk), .reset(reset), .set_n(set_n), .start_stop_n(start_stop_n),
      .tick(tick), .sw(sw), .time_zero(time_zero),
      .secs_load(secs_load), .mins_load(mins_load), .dec_en(dec_en),
      .flash_en(flash_en), .sw_sec_en(sw_sec_en), .sw_min_en(sw_min_en),
      .err(err), .state(state)
   );

   // clock / reset
   always #10 clk = ~clk;

   logic [W-1:0] exp_q[$];
   int total = 0;
   int bad = 0;

   // reference model: 0 idle,1 secs,2 mins,3 ready,4 run,5 pause,6 alarm
   int mState = 0;
   int mTicks = 0;
   bit mErr = 1'b0;

   function automatic bit secs_ok(input logic [7:0] v);
`ifdef COUNTDOWN_BCD_CHECK_EN
      return ((v % 16) < 10) && ((v / 16) < 6);
`else
      return 1'b1;
`endif
   endfunction

   function automatic bit mins_ok(input logic [7:0] v);
`ifdef COUNTDOWN_BCD_CHECK_EN
      return ((v % 16) < 10) && ((v / 16) < 10);
`else
      return 1'b1;
`endif
   endfunction

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_set(input logic [7:0] v);
      case (mState)
         0: mState = 1;
         1: if (secs_ok(v)) begin
               exp_q.push_back({2'd1, v});
               mErr = 1'b0;
               mState = 2;
            end else mErr = 1'b1;
         2: if (mins_ok(v)) begin
               exp_q.push_back({2'd2, v});
               mErr = 1'b0;
               mState = 3;
            end else mErr = 1'b1;
         3, 5: mState = 1;
         6: mState = 0;
         default: ;
      endcase
   endtask

   task automatic model_ss();
      case (mState)
         3: if (!time_zero) mState = 4;
         4: mState = 5;
         5: mState = 4;
         6: mState = 0;
         default: ;
      endcase
   endtask

   task automatic model_settle();
      if (mState == 4 && time_zero) begin
         mState = 6;
         mTicks = 0;
      end
   endtask

   task automatic model_tick();
      if (mState == 4 && !time_zero) exp_q.push_back({2'd3, 8'h00});
      if (mState == 6) begin
         mTicks++;
         if (mTicks == ALARM_TICKS) mState = 0;
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, ".state"}, int'(state), mState);
      check({tag, ".err"}, int'(err), int'(mErr));
      check({tag, ".flash_en"}, int'(flash_en), int'(mState == 6));
      check({tag, ".sw_sec_en"}, int'(sw_sec_en), int'(mState == 1));
      check({tag, ".sw_min_en"}, int'(sw_min_en), int'(mState == 2));
   endtask

   // driver tasks
   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      mState = 0;
      mTicks = 0;
      mErr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   // kind: 0 = SET, 1 = START/STOP, 2 = both together
   task automatic press(input int kind, input logic [7:0] v, input string tag);
      @(posedge clk); #1;
      sw = v;
      if (kind != 1) set_n = 1'b0;
      if (kind != 0) start_stop_n = 1'b0;
      if (kind == 0) model_set(v);
      else if (kind == 1) model_ss();
      else if (mState <= 2) model_set(v);
      else model_ss();
      model_settle();
      repeat (3) @(posedge clk);
      #1;
      set_n = 1'b1;
      start_stop_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check_state(tag);
   endtask

   task automatic do_tick(input string tag);
      @(posedge clk); #1;
      tick = 1'b1;
      model_tick();
      @(posedge clk); #1;
      tick = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_state(tag);
   endtask

   task automatic set_tz(input logic v, input string tag);
      @(posedge clk); #1;
      time_zero = v;
      model_settle();
      repeat (3) @(posedge clk);
      #1;
      check_state(tag);
   endtask

   task automatic to_run();
      do_reset();
      press(0, 8'h00, "go.set");
      press(0, 8'h12, "go.secs");
      press(0, 8'h01, "go.mins");
      press(1, 8'h00, "go.start");
   endtask

   // scoreboard monitor
   task automatic mon_pop(input logic [W-1:0] act, input string name);
      logic [W-1:0] req;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL %s: unexpected strobe code %h, none expected at %0t", name, act, $time);
      end else begin
         req = exp_q.pop_front();
         if (act != req) begin
            bad++;
            $display("FAIL %s: got code %h expected %h at %0t", name, act, req, $time);
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (secs_load === 1'b1) mon_pop({2'd1, sw}, "secs_load");
         if (mins_load === 1'b1) mon_pop({2'd2, sw}, "mins_load");
         if (dec_en === 1'b1) mon_pop({2'd3, 8'h00}, "dec_en");
      end
   end

   initial begin
      int r;
      logic [7:0] v;

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_state("reset");
      check("reset.dec_en", int'(dec_en), 0);

      // entry and start latency
      press(0, 8'h00, "idle_set");
      press(0, 8'h30, "secs30");
      press(0, 8'h01, "mins01");
      @(posedge clk); #1;
      start_stop_n = 1'b0;
      model_ss();
      repeat (3) @(posedge clk);
      #1;
      check("start.pre", int'(state), 3);
      @(posedge clk); #1;
      check("start.lat", int'(state), 4);
      start_stop_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check_state("start");

      // run, pause after the third tick
      do_tick("run.t1");
      do_tick("run.t2");
      do_tick("run.t3");
      press(1, 8'h00, "pause");
      do_tick("pause.t4");
      do_tick("pause.t5");

      // entry validation
      press(0, 8'h00, "pause_set");
      press(0, 8'h75, "bcd75");
      press(0, 8'h3A, "bcd3A");
      press(0, 8'h45, "bcd45");

      // alarm expiring by ticks
      to_run();
      set_tz(1'b1, "alarm.enter");
      for (int i = 0; i < ALARM_TICKS; i++) do_tick("alarm.tick");
      set_tz(1'b0, "alarm.tz0");

      // alarm cut short by SET
      to_run();
      set_tz(1'b1, "alarm2.enter");
      do_tick("alarm2.t1");
      do_tick("alarm2.t2");
      press(0, 8'h00, "alarm2.set");
      set_tz(1'b0, "alarm2.tz0");

      // simultaneous key presses
      to_run();
      press(1, 8'h00, "both.pause");
      press(2, 8'h00, "both.pause_run");
      do_reset();
      press(2, 8'h00, "both.idle");

      // reset in RUN with a coincident tick
      to_run();
      @(posedge clk); #1;
      reset = 1'b1;
      tick = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      tick = 1'b0;
      mState = 0;
      mTicks = 0;
      mErr = 1'b0;
      check("rst.dec_en", int'(dec_en), 0);
      check("rst.secs_load", int'(secs_load), 0);
      check("rst.mins_load", int'(mins_load), 0);
      repeat (2) @(posedge clk);
      #1;
      check_state("rst");

      // randomized event stream
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         if ($urandom_range(0, 1) == 1) v = 8'($urandom_range(0, 255));
         else v = 8'({$urandom_range(0, 9), 4'($urandom_range(0, 9))});
         if (r <= 2) press(0, v, "rnd.set");
         else if (r <= 4) press(1, v, "rnd.ss");
         else if (r <= 7) do_tick("rnd.tick");
         else if (r == 8) press(2, v, "rnd.both");
         else set_tz(($urandom_range(0, 2) == 0), "rnd.tz");
      end

      repeat (4) @(posedge clk);
      #1;
      check("leftover", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
